mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE, GRANT, DRAIN)
//   DEF_*        : default widths and limits for mem_arbiter
//   clog2()      : elaboration-time ceil(log2(v)), returns 0 for v <= 1
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_N        = 2;
    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_HOLD_MAX = 1024;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational N-way round-robin picker.
//   req  : request vector
//   last : index of the most recently granted requester
//   pick : one-hot winner, the first requester found scanning from last+1 modulo N
//   any  : at least one request is present
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned LW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          any
);

    always_comb begin
        pick = '0;
        any  = |req;
        // Scan from the far end so the requester closest after 'last' overwrites the others.
        for (int k = int'(N); k >= 1; k--) begin
            automatic int idx = (int'(last) + k) % int'(N);
            if (req[idx]) begin
                pick = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between N masters.
// A grant is held for as long as the master keeps its request, so multi-access
// sequences are atomic. After release the arbiter waits in DRAIN until the memory
// drops its ready, so the next master never sees a stale completion.
//   clk, rst_n            : clock, asynchronous active-low reset
//   m_req/m_gnt/m_ready   : per-master request, one-hot grant, gated memory_ready
//   m_addr/m_wdata        : flattened per-master address and write data
//   m_rd_en/m_wr_en       : per-master strobes (ignored unless granted)
//   m_rdata               : memory read data broadcast to all masters
//   mem_*                 : single memory port
//   busy                  : arbiter not idle
//   hold_ovf              : sticky flag, a grant ran to HOLD_MAX while another master waited
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          m_req,
    output logic [N-1:0]          m_gnt,
    input  logic [N*ADDR_W-1:0]   m_addr,
    input  logic [N*DATA_W-1:0]   m_wdata,
    input  logic [N-1:0]          m_rd_en,
    input  logic [N-1:0]          m_wr_en,
    output logic [N-1:0]          m_ready,
    output logic [DATA_W-1:0]     m_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  hold_ovf
);

    localparam int unsigned LW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam int unsigned HW = (clog2(HOLD_MAX + 1) > 0) ? clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HoldMax = HW'(HOLD_MAX);

    arb_state_t    r_state;
    logic [N-1:0]  r_gnt;
    logic [LW-1:0] r_last;
    logic [HW-1:0] r_hold;
    logic          r_ovf;

    logic [N-1:0]  w_pick;
    logic          w_any;
    logic [LW-1:0] w_pick_idx;
    logic          w_live;
    logic          w_others;

    mem_rr_pick #(
        .N  (N),
        .LW (LW)
    ) u_pick (
        .req  (m_req),
        .last (r_last),
        .pick (w_pick),
        .any  (w_any)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_pick[i]) w_pick_idx = LW'(i);
        end
    end

    assign w_live   = |(m_req & r_gnt);
    assign w_others = |(m_req & ~r_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= LW'(N - 1);
            r_hold  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_last  <= w_pick_idx;
                        r_hold  <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // Diagnostic only: the holder is never preempted.
                    if (r_hold == HoldMax && w_others) r_ovf <= 1'b1;
                    if (!w_live) begin
                        r_gnt   <= '0;
                        r_state <= DRAIN;
                    end else if (r_hold != HoldMax) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!mem_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_gnt is non-zero only in GRANT, so the port is all-zero in IDLE and DRAIN
    // and drops immediately when reset clears the grant.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_gnt[i] && m_req[i]) begin
                mem_addr  = m_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = m_wdata[i*DATA_W +: DATA_W];
                mem_rd_en = m_rd_en[i];
                mem_wr_en = m_wr_en[i];
            end
        end
    end

    assign m_gnt    = r_gnt;
    assign m_ready  = r_gnt & {N{mem_ready}};
    assign m_rdata  = mem_rdata;
    assign busy     = (r_state != IDLE);
    assign hold_ovf = r_ovf;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int HM = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_gnt;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_rd_en = '0;
    logic [N-1:0]    m_wr_en = '0;
    logic [N-1:0]    m_ready;
    logic [DW-1:0]   m_rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic            mem_ready = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic            busy;
    logic            hold_ovf;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .N        (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .HOLD_MAX (HM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_req     (m_req),
        .m_gnt     (m_gnt),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rd_en   (m_rd_en),
        .m_wr_en   (m_wr_en),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .hold_ovf  (hold_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        if (i == 16) return 8'hAB;
        return 8'((i * 7 + 3) ^ 90);
    endfunction

    // Round-robin rule: first requester after 'last', modulo N.
    function automatic int rr_model(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            automatic int idx = (last + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory: 4-phase, 1-cycle response, programmable tail ----------------
    logic [7:0] mem_store [0:255];
    int tail_extra = 0;
    int tail_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem_store[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!mem_ready) begin
                if (mem_rd_en || mem_wr_en) begin
                    mem_ready <= 1'b1;
                    if (mem_wr_en) mem_store[mem_addr[7:0]] <= mem_wdata;
                    else           mem_rdata <= mem_store[mem_addr[7:0]];
                end
            end else if (!(mem_rd_en || mem_wr_en)) begin
                if (tail_cnt >= tail_extra) begin
                    mem_ready <= 1'b0;
                    tail_cnt  <= 0;
                end else begin
                    tail_cnt <= tail_cnt + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int         m;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [0:255];
    int         ready_cnt [N];
    logic [N-1:0] prev_ready = '0;

    always @(negedge clk) begin
        exp_t e;
        if (m_ready != '0 && prev_ready == '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=%b required=none", m_ready);
            end else begin
                e = exp_q.pop_front();
                ready_cnt[e.m]++;
                chk("ready_sel", 32'(m_ready), 32'(1) << e.m);
                chk("mem_addr", mem_addr, {24'b0, e.addr});
                if (e.wr) begin
                    chk("mem_wr_en", 32'(mem_wr_en), 32'd1);
                    chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
                end else begin
                    chk("mem_rd_en", 32'(mem_rd_en), 32'd1);
                    chk("m_rdata", 32'(m_rdata), 32'(e.data));
                end
            end
        end
        prev_ready <= m_ready;
    end

    // ---------------- master helpers ----------------
    task automatic access(input int m, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input bit wait_low);
        exp_t e;
        int n;
        e.m = m; e.wr = wr; e.addr = a;
        if (wr) begin
            e.data = d;
            ref_mem[a] = d;
        end else begin
            e.data = ref_mem[a];
        end
        exp_q.push_back(e);
        m_addr[m*AW +: AW]  = {24'b0, a};
        m_wdata[m*DW +: DW] = d;
        if (wr) m_wr_en[m] = 1'b1;
        else    m_rd_en[m] = 1'b1;
        n = 0;
        while (!m_ready[m] && n < 50) begin cyc(); n++; end
        if (n >= 50) chk("ready_timeout", 32'(m_ready[m]), 32'd1);
        cyc();
        m_wr_en[m] = 1'b0;
        m_rd_en[m] = 1'b0;
        if (wait_low) begin
            n = 0;
            while (m_ready[m] && n < 50) begin cyc(); n++; end
            if (n >= 50) chk("ready_low_timeout", 32'(m_ready[m]), 32'd0);
        end
    endtask

    task automatic wait_gnt(output int g);
        int n;
        n = 0;
        g = -1;
        while (m_gnt == '0 && n < 50) begin cyc(); n++; end
        if (n >= 50) begin
            chk("gnt_timeout", 32'(m_gnt), 32'd1);
        end else begin
            chk("gnt_onehot", 32'($countones(m_gnt)), 32'd1);
            for (int i = 0; i < N; i++) if (m_gnt[i]) g = i;
        end
    endtask

    task automatic wait_gnt_is(input string name, input logic [N-1:0] val);
        int n;
        n = 0;
        while (m_gnt != val && n < 50) begin cyc(); n++; end
        chk(name, 32'(m_gnt), 32'(val));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || mem_ready) && n < 50) begin cyc(); n++; end
        if (n >= 50) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        m_req = '0; m_rd_en = '0; m_wr_en = '0;
        wait_idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, e, model_last, base, drain_cycles, drain_bad, n, nacc;
        logic [7:0] d1, d2;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;

        // Reset values while reset is held.
        #12;
        chk("rst_gnt", 32'(m_gnt), 32'd0);
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(hold_ovf), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset -> first access: port 0 wins, one edge of latency.
        m_req = 3'b011;
        cyc();
        chk("first_gnt", 32'(m_gnt), 32'd1);
        model_last = 0;
        access(0, 1'b0, 8'h10, 8'h00, 1'b1);
        chk("first_rdata_ref", 32'(ref_mem[16]), 32'hAB);

        // Handoff with memory ready stretched 3 cycles past the strobe.
        tail_extra = 3;
        access(0, 1'b0, 8'h20, 8'h00, 1'b0);
        m_req[0] = 1'b0;
        drain_cycles = 0;
        drain_bad = 0;
        n = 0;
        while (m_gnt == '0 || m_gnt[0]) begin
            if (busy && m_gnt == '0) begin
                drain_cycles++;
                if (mem_rd_en || mem_wr_en || m_ready != '0) drain_bad++;
            end
            cyc();
            n++;
            if (n >= 50) break;
        end
        chk("drain_strobes", 32'(drain_bad), 32'd0);
        chk("drain_stretched", 32'(drain_cycles >= 3), 32'd1);
        chk("handoff_gnt", 32'(m_gnt), 32'd2);
        m_req[1] = 1'b0;
        tail_extra = 0;
        wait_idle();

        // Round-robin fairness: everyone requesting, two accesses per turn.
        do_reset();
        m_req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_gnt(g);
            chk("rr_order", 32'(g), 32'(t % 3));
            if (g < 0) break;
            access(g, 1'($urandom_range(0, 1)), 8'($urandom_range(64, 95)), 8'($urandom), 1'b1);
            access(g, 1'($urandom_range(0, 1)), 8'($urandom_range(64, 95)), 8'($urandom), 1'b1);
            m_req[g] = 1'b0;
            cyc();
            m_req[g] = 1'b1;
        end
        m_req = '0;
        wait_idle();

        // Atomic sequence on master 1 while master 0 waits.
        m_req = 3'b010;
        wait_gnt(g);
        chk("atomic_gnt", 32'(g), 32'd1);
        base = ready_cnt[1];
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        access(1, 1'b1, 8'h55, d1, 1'b1);
        access(1, 1'b1, 8'h56, d2, 1'b1);
        m_req[0] = 1'b1;
        cyc();
        chk("atomic_hold1", 32'(m_gnt), 32'd2);
        access(1, 1'b0, 8'h55, 8'h00, 1'b1);
        chk("atomic_hold2", 32'(m_gnt), 32'd2);
        chk("atomic_count", 32'(ready_cnt[1] - base), 32'd3);
        m_req[1] = 1'b0;
        wait_gnt_is("atomic_next", 3'b001);
        m_req = '0;
        wait_idle();

        // Starvation flag with master 1 waiting.
        do_reset();
        m_req = 3'b001;
        cyc();
        chk("starve_gnt", 32'(m_gnt), 32'd1);
        m_req[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == HM - 1) chk("ovf_early", 32'(hold_ovf), 32'd0);
            if (k == HM + 2) chk("ovf_set", 32'(hold_ovf), 32'd1);
        end
        m_req[0] = 1'b0;
        wait_gnt_is("starve_next", 3'b010);
        chk("ovf_sticky", 32'(hold_ovf), 32'd1);
        m_req = '0;
        wait_idle();

        // Same long hold with nobody waiting: no flag.
        do_reset();
        m_req = 3'b001;
        for (int k = 0; k < 21; k++) cyc();
        chk("ovf_alone", 32'(hold_ovf), 32'd0);
        m_req = '0;
        wait_idle();
        chk("ovf_alone_after", 32'(hold_ovf), 32'd0);

        // Async reset mid-write; last grant was master 0.
        m_req = 3'b001;
        cyc();
        chk("rstw_gnt", 32'(m_gnt), 32'd1);
        m_addr[0 +: AW] = 32'h30;
        m_wdata[0 +: DW] = 8'h77;
        m_wr_en[0] = 1'b1;
        #1;
        chk("rstw_wr_before", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rstw_gnt0", 32'(m_gnt), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        m_wr_en = '0;
        m_req = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        m_req = 3'b111;
        cyc();
        chk("rstw_port0", 32'(m_gnt), 32'd1);
        m_req = '0;
        wait_idle();
        model_last = 0;

        // Randomized traffic against the round-robin rule.
        for (int it = 0; it < 25; it++) begin
            m_req = m_req | 3'($urandom_range(0, 7));
            if (m_req == '0) m_req[$urandom_range(0, N - 1)] = 1'b1;
            wait_gnt(g);
            e = rr_model(m_req, model_last);
            chk("rand_rr", 32'(g), 32'(e));
            if (g < 0) break;
            model_last = e;
            tail_extra = $urandom_range(0, 2);
            nacc = $urandom_range(1, 3);
            for (int a = 0; a < nacc; a++) begin
                access(g, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom),
                       1'b1);
            end
            m_req[g] = 1'b0;
            cyc();
        end
        m_req = '0;
        wait_idle();
        cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
